// File: rtl/simon_if.sv
// simon_if: engine inputs (start, random source, player buttons) and outputs.
// master drives the engine inputs; slave is the engine side.
interface simon_if #(
  parameter int NUM_BTNS = 4,
  parameter int MAX_LEN  = 16
);
  localparam int SEL_W =
    (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1;
  localparam int SCORE_W = $clog2(MAX_LEN + 1);

  logic               start_i;
  logic [SEL_W-1:0]   rand_i;
  logic [SEL_W-1:0]   player_num_i;
  logic               player_pressed_i;
  logic               simon_turn_o;
  logic [SEL_W-1:0]   simon_num_o;
  logic               simon_pressed_o;
  logic               game_over_o;
  logic               win_o;
  logic [SCORE_W-1:0] score_o;

  modport master (
    output start_i, rand_i,
    output player_num_i, player_pressed_i,
    input  simon_turn_o, simon_num_o,
    input  simon_pressed_o, game_over_o,
    input  win_o, score_o
  );

  modport slave (
    input  start_i, rand_i,
    input  player_num_i, player_pressed_i,
    output simon_turn_o, simon_num_o,
    output simon_pressed_o, game_over_o,
    output win_o, score_o
  );
endinterface

// File: rtl/simon_engine.sv
// simon_engine: grows a random sequence, plays it back, checks presses.
// Define SIMON_TIMEOUT_EN to end the game on player inactivity.
module simon_engine #(
  parameter int NUM_BTNS      = 4,
  parameter int MAX_LEN       = 16,
  parameter int TICK_DIV      = 25000000,
  parameter int ON_TICKS      = 2,
  parameter int OFF_TICKS     = 1,
  parameter int TIMEOUT_TICKS = 10
) (
  input logic    clk,
  input logic    reset,
  simon_if.slave bus
);
  localparam int SEL_W =
    (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1;
  localparam int SCORE_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W =
    (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int T_A =
    (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int T_MAX =
    (T_A > TIMEOUT_TICKS) ? T_A : TIMEOUT_TICKS;
  localparam int TCNT_W = $clog2(T_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADD, S_PLAY_ON, S_PLAY_OFF,
    S_WAIT_PRESS, S_WAIT_REL, S_GAP,
    S_OVER, S_WIN
  } state_e;

  state_e state_q, state_d;

  logic [SEL_W-1:0]   mem_q [MAX_LEN];
  logic [SCORE_W-1:0] len_q, len_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
  logic               prev_q;
  logic               turn_q, turn_d;
  logic               press_q, press_d;
  logic [SEL_W-1:0]   num_q, num_d;
  logic               over_q, over_d;
  logic               win_q, win_d;

  logic               add_wr;
  logic               tick;
  logic               idx_last;
  logic               rise;
  logic [SEL_W-1:0]   rnd_mod;
  logic [IDX_W-1:0]   wr_idx;

  assign tick = div_q == DIV_W'(TICK_DIV - 1);
  assign idx_last =
    (SCORE_W'(idx_q) + SCORE_W'(1)) == len_q;
  assign rise = bus.player_pressed_i & ~prev_q;
  assign rnd_mod =
    SEL_W'(32'(bus.rand_i) % 32'(NUM_BTNS));
  assign wr_idx = len_q[IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    score_d = score_q;
    add_wr  = 1'b0;
    unique case (state_q)
      S_IDLE, S_OVER, S_WIN: begin
        if (bus.start_i) begin
          len_d   = '0;
          score_d = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        add_wr  = 1'b1;
        len_d   = len_q + 1'b1;
        idx_d   = '0;
        state_d = S_PLAY_ON;
      end
      S_PLAY_ON: begin
        if (tick &&
            tcnt_q == TCNT_W'(ON_TICKS - 1))
          state_d = S_PLAY_OFF;
      end
      S_PLAY_OFF: begin
        if (tick &&
            tcnt_q == TCNT_W'(OFF_TICKS - 1)) begin
          if (idx_last) begin
            idx_d   = '0;
            state_d = S_WAIT_PRESS;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_PLAY_ON;
          end
        end
      end
      S_WAIT_PRESS: begin
        if (rise) begin
          if (bus.player_num_i == mem_q[idx_q])
            state_d = S_WAIT_REL;
          else
            state_d = S_OVER;
        end
`ifdef SIMON_TIMEOUT_EN
        else if (tick &&
            tcnt_q == TCNT_W'(TIMEOUT_TICKS - 1))
          state_d = S_OVER;
`endif
      end
      S_WAIT_REL: begin
        if (!bus.player_pressed_i) begin
          if (idx_last) begin
            score_d = len_q;
            if (len_q == SCORE_W'(MAX_LEN))
              state_d = S_WIN;
            else
              state_d = S_GAP;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_WAIT_PRESS;
          end
        end
      end
      S_GAP: begin
        if (tick &&
            tcnt_q == TCNT_W'(OFF_TICKS - 1))
          state_d = S_ADD;
      end
      default: state_d = S_IDLE;
    endcase

    // Timing restarts from zero on every state entry.
    if (state_d != state_q) begin
      div_d  = '0;
      tcnt_d = '0;
    end else begin
      div_d  = tick ? '0 : div_q + 1'b1;
      tcnt_d = tick ? tcnt_q + 1'b1 : tcnt_q;
    end

    turn_d  = state_d inside
      {S_ADD, S_PLAY_ON, S_PLAY_OFF, S_GAP};
    press_d = state_d == S_PLAY_ON;
    over_d  = state_d == S_OVER;
    win_d   = state_d == S_WIN;
    num_d   = num_q;
    // Forward the value being stored this cycle.
    if (press_d) begin
      if (add_wr && wr_idx == idx_d)
        num_d = rnd_mod;
      else
        num_d = mem_q[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (add_wr) mem_q[wr_idx] <= rnd_mod;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      score_q <= '0;
      div_q   <= '0;
      tcnt_q  <= '0;
      prev_q  <= 1'b0;
      turn_q  <= 1'b0;
      press_q <= 1'b0;
      num_q   <= '0;
      over_q  <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      score_q <= score_d;
      div_q   <= div_d;
      tcnt_q  <= tcnt_d;
      prev_q  <= bus.player_pressed_i;
      turn_q  <= turn_d;
      press_q <= press_d;
      num_q   <= num_d;
      over_q  <= over_d;
      win_q   <= win_d;
    end
  end

  assign bus.simon_turn_o    = turn_q;
  assign bus.simon_num_o     = num_q;
  assign bus.simon_pressed_o = press_q;
  assign bus.game_over_o     = over_q;
  assign bus.win_o           = win_q;
  assign bus.score_o         = score_q;
endmodule

// File: tb/tb_simon_engine.sv
// tb_simon_engine: random games against a round-level model of the game.
// The model predicts all outputs each cycle from the game rules.
module tb_simon_engine;
  localparam int NB  = 4;
  localparam int ML  = 3;
  localparam int TD  = 4;
  localparam int ON  = 2;
  localparam int OFF = 1;
  localparam int TO  = 10;

  logic clk = 1'b0;
  logic reset;

  simon_if #(.NUM_BTNS(NB), .MAX_LEN(ML)) bus();
  simon_if #(.NUM_BTNS(5), .MAX_LEN(ML)) bus5();

  simon_engine #(
    .NUM_BTNS(NB), .MAX_LEN(ML), .TICK_DIV(TD),
    .ON_TICKS(ON), .OFF_TICKS(OFF),
    .TIMEOUT_TICKS(TO)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  simon_engine #(
    .NUM_BTNS(5), .MAX_LEN(ML), .TICK_DIV(TD),
    .ON_TICKS(ON), .OFF_TICKS(OFF),
    .TIMEOUT_TICKS(TO)
  ) dut5 (.clk(clk), .reset(reset), .bus(bus5));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int seq[$];
  int exp_turn, exp_pr, exp_num;
  int exp_over, exp_win, exp_score;
  bit chk_en = 1'b0;
  int hi_cnt = 0;

  function automatic void chk(string n,
      logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t",
        n, act, expv, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("turn", 32'(bus.simon_turn_o), exp_turn);
      chk("strobe", 32'(bus.simon_pressed_o), exp_pr);
      chk("num", 32'(bus.simon_num_o), exp_num);
      chk("over", 32'(bus.game_over_o), exp_over);
      chk("win", 32'(bus.win_o), exp_win);
      chk("score", 32'(bus.score_o), exp_score);
    end
    if (bus.simon_pressed_o === 1'b1) hi_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
    bus.rand_i = 2'($urandom);
  endtask

  task automatic noise();
    bus.player_pressed_i = ($urandom % 3) == 0;
    bus.player_num_i = 2'($urandom);
  endtask

  task automatic do_start(input bit with_press);
    bus.player_pressed_i = 1'b0;
    bus.start_i = 1'b1;
    if (with_press) begin
      bus.player_pressed_i = 1'b1;
      bus.player_num_i = 2'($urandom);
    end
    seq.delete();
    exp_turn = 1; exp_pr = 0;
    exp_over = 0; exp_win = 0; exp_score = 0;
    step();
    bus.start_i = 1'b0;
    bus.player_pressed_i = 1'b0;
  endtask

  // Called in ADD; res: 0 next round, 1 over, 2 win.
  task automatic run_round(input int r, input int bad_i,
      input int bad_off, input bit longw,
      output int res);
    int held;
    bus.rand_i = 2'(r);
    seq.push_back(r % NB);
    foreach (seq[i]) begin
      exp_pr = 1; exp_num = seq[i]; exp_turn = 1;
      repeat (ON * TD) begin noise(); step(); end
      exp_pr = 0;
      repeat (OFF * TD) begin noise(); step(); end
    end
    held = longw ? 0 : int'($urandom % 2);
    bus.player_pressed_i = held[0];
    bus.player_num_i = 2'((seq[0] + 1) % NB);
    exp_turn = 0;
    step();
    if (longw) begin
`ifdef SIMON_TIMEOUT_EN
      repeat (TO * TD - 1) step();
      exp_over = 1;
      step();
      res = 1;
      return;
`else
      repeat (1000) step();
`endif
    end
    if (held != 0) begin
      repeat (2) step();
      bus.player_pressed_i = 1'b0;
      step();
    end
    repeat ($urandom % 3) step();
    foreach (seq[i]) begin
      bus.player_pressed_i = 1'b1;
      if (i == bad_i) begin
        bus.player_num_i = 2'((seq[i] + bad_off) % NB);
        exp_over = 1;
        step();
        bus.player_pressed_i = 1'b0;
        res = 1;
        return;
      end
      bus.player_num_i = 2'(seq[i]);
      step();
      repeat ($urandom % 3) begin
        bus.player_num_i = 2'($urandom);
        step();
      end
      bus.player_pressed_i = 1'b0;
      if (i == seq.size() - 1) begin
        exp_score = seq.size();
        if (seq.size() == ML) begin
          exp_win = 1;
          step();
          res = 2;
          return;
        end
        exp_turn = 1;
        step();
        repeat (OFF * TD) step();
        res = 0;
        return;
      end
      step();
    end
    res = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int res, base, rv, bad, off, g;
    reset = 1'b1;
    bus.start_i = 0; bus.rand_i = 0;
    bus.player_num_i = 0; bus.player_pressed_i = 0;
    bus5.start_i = 0; bus5.rand_i = 0;
    bus5.player_num_i = 0; bus5.player_pressed_i = 0;
    exp_turn = 0; exp_pr = 0; exp_num = 0;
    exp_over = 0; exp_win = 0; exp_score = 0;
    chk_en = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (3) step();

    bus5.start_i = 1'b1;
    step();
    bus5.start_i = 1'b0;
    bus5.rand_i = 3'd6;
    step();
    chk("mod5_strobe", 32'(bus5.simon_pressed_o), 1);
    chk("mod5_num", 32'(bus5.simon_num_o), 1);

    base = hi_cnt;
    do_start(0);
    run_round(2, -1, 0, 0, res);
    chk("r1_num", 32'(bus.simon_num_o), 2);
    chk("r1_hi_cycles", hi_cnt - base, 8);
    chk("r1_score", 32'(bus.score_o), 1);
    run_round(1, -1, 0, 0, res);
    run_round(3, -1, 0, 0, res);
    chk("g1_res", res, 2);
    chk("g1_win", 32'(bus.win_o), 1);
    chk("g1_over", 32'(bus.game_over_o), 0);
    chk("g1_score", 32'(bus.score_o), 3);
    chk("g1_hi_total", hi_cnt - base, 48);

    do_start(1);
    run_round(int'($urandom % 4), -1, 0, 0, res);
    run_round(1, 1, 3, 0, res);
    chk("g2_over", 32'(bus.game_over_o), 1);
    chk("g2_score", 32'(bus.score_o), 1);

    do_start(1);
    res = 0;
    run_round(int'($urandom % 4), -1, 0, 1, res);
    g = 1;
    while (res == 0 && g < ML) begin
      run_round(int'($urandom % 4), -1, 0, 0, res);
      g++;
    end
`ifdef SIMON_TIMEOUT_EN
    chk("timeout_over", 32'(bus.game_over_o), 1);
`else
    chk("no_timeout_win", 32'(bus.win_o), 1);
`endif

    do_start(0);
    rv = int'($urandom % 4);
    bus.rand_i = 2'(rv);
    exp_pr = 1; exp_num = rv;
    repeat (3) step();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_strobe", 32'(bus.simon_pressed_o), 0);
    chk("rst_turn", 32'(bus.simon_turn_o), 0);
    chk("rst_num", 32'(bus.simon_num_o), 0);
    exp_turn = 0; exp_pr = 0; exp_num = 0;
    exp_over = 0; exp_win = 0; exp_score = 0;
    step();
    reset = 1'b0;
    repeat (5) begin noise(); step(); end
    bus.player_pressed_i = 1'b0;

    repeat (10) begin
      do_start(1'($urandom));
      res = 0;
      while (res == 0) begin
        if ($urandom % 4 == 0)
          bad = int'($urandom % (seq.size() + 1));
        else
          bad = -1;
        off = 1 + int'($urandom % 3);
        run_round(int'($urandom % 4), bad, off, 0, res);
      end
      repeat ($urandom % 4) step();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/simon_engine.md
# simon_engine

Parametrised Simon sequence engine: stores a growing pseudo-random sequence, plays it back as timed button strobes, then checks the player's presses against it. It replaces the fixed 4-button game core. It sits between the button interpreter/random source and the LED, speaker and display drivers. Button count, maximum sequence length and all playback timing are parameters; win detection, score output and an optional input timeout are included.

## Interface
- NUM_BTNS, 4: number of buttons/channels, ≥2.
- MAX_LEN, 16: maximum sequence length; reaching it wins.
- TICK_DIV, 25000000: clk cycles per timing tick, ≥2.
- ON_TICKS, 2: ticks each playback strobe is high.
- OFF_TICKS, 1: ticks of gap after each strobe, and before each new round.
- TIMEOUT_TICKS, 10: player inactivity limit in ticks (SIMON_TIMEOUT_EN only).
- SEL_W = max(1, clog2(NUM_BTNS)); SCORE_W = clog2(MAX_LEN+1) (localparams).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; sampled high in IDLE, OVER or WIN to begin a new game.
- rand  in  SEL_W  free-running random value; reduced modulo NUM_BTNS when captured.
- player_num  in  SEL_W  index of the pressed button; valid while player_pressed is high.
- player_pressed  in  1  level; high while any button is held.
- simon_turn  out  1  high while the engine owns the outputs (playback or gap).
- simon_num  out  SEL_W  button being played back.
- simon_pressed  out  1  playback strobe.
- game_over  out  1  high in OVER.
- win  out  1  high in WIN.
- score  out  SCORE_W  number of rounds completed.

## Operation
- Sequence storage: MAX_LEN × SEL_W registers; len (0..MAX_LEN) and idx (0..MAX_LEN-1) counters.
- Tick divider: counts 0..TICK_DIV-1; restarts at 0 on every state entry; a tick fires when the count hits TICK_DIV-1. The per-state tick counter clears on state entry.
- IDLE: all outputs 0. start=1 → clear len and score → ADD.
- ADD (1 cycle): mem[len] ← rand mod NUM_BTNS; len++; idx ← 0 → PLAY_ON.
- PLAY_ON: simon_pressed=1, simon_num=mem[idx]; after ON_TICKS ticks → PLAY_OFF.
- PLAY_OFF: simon_pressed=0, simon_num holds; after OFF_TICKS ticks: if idx=len-1 then idx ← 0, WAIT_PRESS; otherwise idx++ → PLAY_ON.
- WAIT_PRESS: simon_turn=0. A rising edge of player_pressed (registered previous value) compares player_num to mem[idx]: mismatch → OVER; match → WAIT_RELEASE.
- WAIT_RELEASE: on player_pressed=0: if idx=len-1 then score ← len, and if len=MAX_LEN → WIN, else → GAP; otherwise idx++ → WAIT_PRESS.
- GAP: simon_turn=1, strobe 0; after OFF_TICKS ticks → ADD.
- OVER / WIN: hold outputs; start=1 → clear len and score → ADD.
- simon_turn=1 in ADD, PLAY_ON, PLAY_OFF, GAP; 0 in every other state.
- player_pressed is ignored outside WAIT_PRESS/WAIT_RELEASE. A press already held when WAIT_PRESS is entered does not count until it is released and pressed again.

## Timing
- Reset (async, any state): state=IDLE; all outputs, len, idx, score, dividers and edge register are 0. Sequence memory is not cleared.
- start → ADD in the next cycle; first simon_pressed rises one cycle after ADD.
- PLAY_ON lasts exactly ON_TICKS×TICK_DIV cycles; PLAY_OFF and GAP each last OFF_TICKS×TICK_DIV cycles.
- Press decision (OVER or WAIT_RELEASE) comes 1 cycle after the sampled rising edge.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- If start and a press occur in the same cycle in OVER/WIN, start wins; the press is ignored.

## Configuration
- SIMON_TIMEOUT_EN defined: WAIT_PRESS counts ticks and enters OVER after TIMEOUT_TICKS ticks with no rising edge. The count clears on every WAIT_PRESS entry.
- SIMON_TIMEOUT_EN undefined: WAIT_PRESS waits indefinitely; TIMEOUT_TICKS is unused.

## Test plan
Parameters for all scenarios: NUM_BTNS=4, MAX_LEN=3, TICK_DIV=4, ON_TICKS=2, OFF_TICKS=1.
- Reset mid-PLAY_ON → all outputs 0 immediately; the engine stays in IDLE until start.
- start with rand=2 → simon_pressed high for 8 cycles with simon_num=2, low for 4 cycles, then simon_turn=0.
- Correct presses for 3 rounds (rand=2, 1, 3) → score steps 1, 2, 3; win=1; game_over=0.
- Round 2 with wrong player_num=0 where mem[1]=1 → game_over=1 one cycle after the edge; score=1.
- rand=6 with NUM_BTNS=5, SEL_W=3 → stored and played value is 1.
- With SIMON_TIMEOUT_EN, TIMEOUT_TICKS=10 and no press → game_over=1 exactly 40 cycles after WAIT_PRESS entry. Without the macro → still waiting at 1000 cycles.
